// File: rtl/sn76489_bus_writer_if.sv
// Stream and PSG-bus signals of the SN76489 bus writer.
// The byte source uses the master modport. The writer uses the slave modport.
interface sn76489_bus_writer_if #(
    parameter int FIFO_DEPTH = 4
) ();
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       data;
    logic             web;
    logic             busy;
    logic [LVL_W-1:0] fifo_level;
    logic             done;

    modport master (
        output in_data, in_valid,
        input  in_ready, data, web, busy, fifo_level, done
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, data, web, busy, fifo_level, done
    );
endinterface

// File: rtl/sn76489_bus_writer.sv
// Host-side writer for the SN76489 parallel write port.
// Command bytes arrive on a valid/ready stream and are queued in a small FIFO.
// Each byte is replayed on data/web with programmable setup, strobe, hold and
// recovery timing.
module sn76489_bus_writer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SETUP_CYC   = 2,
    parameter int PULSE_CYC   = 4,
    parameter int HOLD_CYC    = 2,
    parameter int RECOVER_CYC = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  rst_n,
    sn76489_bus_writer_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Each phase counter is loaded with (cycles - 1) and runs down to zero.
    localparam logic [7:0] SETUP_LOAD   = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PULSE_LOAD   = 8'(PULSE_CYC - 1);
    localparam logic [7:0] HOLD_LOAD    = 8'(HOLD_CYC - 1);
    localparam logic [7:0] RECOVER_LOAD = 8'(RECOVER_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER
    } state_t;

    state_t           state_reg, state_next;
    logic [7:0]       cnt_reg, cnt_next;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0] level_reg, level_next;
    logic             in_ready_reg;

    logic [7:0]       data_reg;
    logic             web_reg;
    logic             done_reg;

    logic             push;
    logic             pop;

    assign push       = bus.in_valid && in_ready_reg;
    assign level_next = level_reg + LVL_W'(push) - LVL_W'(pop);

    // FIFO storage has no reset, so it can map onto RAM. The read is
    // registered straight into the data bus register.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= bus.in_data;
        end
    end

    // Next-state logic for the bus cycle sequencer. A byte is popped from
    // IDLE, or from the last RECOVER cycle so back-to-back bytes skip IDLE.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (level_reg != '0) begin
                    pop        = 1'b1;
                    state_next = SETUP;
                    cnt_next   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (cnt_reg == 8'd0) begin
                    state_next = STROBE;
                    cnt_next   = PULSE_LOAD;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            STROBE: begin
                if (cnt_reg == 8'd0) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LOAD;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_reg == 8'd0) begin
                    state_next = RECOVER;
                    cnt_next   = RECOVER_LOAD;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            RECOVER: begin
                if (cnt_reg == 8'd0) begin
                    if (level_reg != '0) begin
                        pop        = 1'b1;
                        state_next = SETUP;
                        cnt_next   = SETUP_LOAD;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = 8'd0;
                    end
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // State, FIFO bookkeeping and registered bus outputs. The asynchronous
    // reset lifts web at once, even in the middle of a strobe.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= 8'd0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            in_ready_reg <= 1'b1;
            data_reg     <= 8'h00;
            web_reg      <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            level_reg    <= level_next;
            // Computed from the next occupancy, so a pop while full only
            // reopens the input on the following cycle.
            in_ready_reg <= (level_next != LVL_W'(FIFO_DEPTH));
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                data_reg   <= mem[rd_ptr_reg];
            end
            web_reg      <= (state_next != STROBE);
            done_reg     <= (state_reg == HOLD) && (state_next == RECOVER);
        end
    end

    assign bus.in_ready   = in_ready_reg;
    assign bus.data       = data_reg;
    assign bus.web        = web_reg;
    assign bus.done       = done_reg;
    assign bus.fifo_level = level_reg;
    assign bus.busy       = (state_reg != IDLE) || (level_reg != '0);
endmodule

// File: tb/tb_sn76489_bus_writer.sv
// Directed testbench for sn76489_bus_writer.
// dut_a uses the default timing, dut_b uses 1-cycle phases.
// Cycle 0 of a scenario is the cycle in which the first byte is presented.
module tb_sn76489_bus_writer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    sn76489_bus_writer_if #(.FIFO_DEPTH(4)) bus_a ();
    sn76489_bus_writer_if #(.FIFO_DEPTH(4)) bus_b ();

    sn76489_bus_writer #(.FIFO_DEPTH(4)) dut_a (
        .wb_clk_i (clk),
        .rst_n    (rst_n),
        .bus      (bus_a)
    );

    sn76489_bus_writer #(
        .FIFO_DEPTH(4), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1), .RECOVER_CYC(1)
    ) dut_b (
        .wb_clk_i (clk),
        .rst_n    (rst_n),
        .bus      (bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Records strobe edges and done pulses of dut_a, sampled on the falling clock edge.
    int         fall_cyc[$];
    logic [7:0] fall_data[$];
    logic [7:0] fall_prev[$];
    int         rise_cyc[$];
    logic [7:0] rise_data[$];
    int         done_cyc[$];
    logic       prev_web = 1'b1;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_web && !bus_a.web) begin
                fall_cyc.push_back(cyc);
                fall_data.push_back(bus_a.data);
                fall_prev.push_back(prev_data);
            end
            if (!prev_web && bus_a.web) begin
                rise_cyc.push_back(cyc);
                rise_data.push_back(bus_a.data);
            end
            if (bus_a.done) done_cyc.push_back(cyc);
        end
        prev_web  <= bus_a.web;
        prev_data <= bus_a.data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        fall_cyc.delete(); fall_data.delete(); fall_prev.delete();
        rise_cyc.delete(); rise_data.delete(); done_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.in_valid = 1'b1; bus_a.in_data = 8'hFF;
        bus_b.in_valid = 1'b1; bus_b.in_data = 8'hFF;
        repeat (3) tick();
        n_cmp++; if (bus_a.web !== 1'b1) begin n_bad++; $display("FAIL rst_web got %b exp 1", bus_a.web); end
        n_cmp++; if (bus_a.data !== 8'h00) begin n_bad++; $display("FAIL rst_data got %h exp 00", bus_a.data); end
        n_cmp++; if (bus_a.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b exp 1", bus_a.in_ready); end
        n_cmp++; if (bus_a.fifo_level !== 3'd0) begin n_bad++; $display("FAIL rst_level got %0d exp 0", bus_a.fifo_level); end
        n_cmp++; if (bus_a.done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b exp 0", bus_a.done); end
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b exp 0", bus_a.busy); end
        n_cmp++; if (bus_b.web !== 1'b1) begin n_bad++; $display("FAIL rst_b_web got %b exp 1", bus_b.web); end
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < 10; c++) begin
            n_cmp++; if (bus_a.web !== 1'b1 || bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) begin
                n_bad++; $display("FAIL post_rst_idle c=%0d got web=%b done=%b busy=%b exp 1/0/0", c, bus_a.web, bus_a.done, bus_a.busy);
            end
            tick();
        end
        $display("reset: released, bus idle");
    endtask

    task automatic test_single();
        logic       exp_web;
        logic [7:0] exp_data;
        bus_a.in_valid = 1'b1; bus_a.in_data = 8'h8E;
        for (int c = 0; c < 20; c++) begin
            if (c == 1) bus_a.in_valid = 1'b0;
            exp_web  = !(c >= 4 && c <= 7);
            exp_data = (c >= 2) ? 8'h8E : 8'h00;
            n_cmp++; if (bus_a.web !== exp_web) begin n_bad++; $display("FAIL single_web c=%0d got %b exp %b", c, bus_a.web, exp_web); end
            n_cmp++; if (bus_a.data !== exp_data) begin n_bad++; $display("FAIL single_data c=%0d got %h exp %h", c, bus_a.data, exp_data); end
            n_cmp++; if (bus_a.done !== (c == 10)) begin n_bad++; $display("FAIL single_done c=%0d got %b exp %b", c, bus_a.done, (c == 10)); end
            // busy is high through cycle 17 (last RECOVER cycle), low from cycle 18
            n_cmp++; if (bus_a.busy !== (c >= 1 && c <= 17)) begin n_bad++; $display("FAIL single_busy c=%0d got %b exp %b", c, bus_a.busy, (c >= 1 && c <= 17)); end
            if (c == 1) begin
                n_cmp++; if (bus_a.fifo_level !== 3'd1) begin n_bad++; $display("FAIL single_level1 got %0d exp 1", bus_a.fifo_level); end
            end
            if (c == 2) begin
                n_cmp++; if (bus_a.fifo_level !== 3'd0) begin n_bad++; $display("FAIL single_level2 got %0d exp 0", bus_a.fifo_level); end
            end
            tick();
        end
        $display("single: byte 8e written");
    endtask

    task automatic test_burst();
        logic [7:0] bytes [4] = '{8'h9F, 8'hBF, 8'hDF, 8'hFF};
        int base;
        clear_mon();
        base = cyc;
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (bus_a.in_ready !== 1'b1) begin n_bad++; $display("FAIL burst_in_ready c=%0d got %b exp 1", c, bus_a.in_ready); end
            bus_a.in_valid = 1'b1; bus_a.in_data = bytes[c];
            tick();
        end
        bus_a.in_valid = 1'b0;
        repeat (70) tick();
        n_cmp++; if (fall_cyc.size() != 4) begin n_bad++; $display("FAIL burst_pulses got %0d exp 4", fall_cyc.size()); end
        n_cmp++; if (done_cyc.size() != 4) begin n_bad++; $display("FAIL burst_dones got %0d exp 4", done_cyc.size()); end
        for (int k = 0; k < 4; k++) begin
            if (k < fall_cyc.size()) begin
                n_cmp++; if (fall_cyc[k] - base != 4 + 16 * k) begin n_bad++; $display("FAIL burst_fall k=%0d got %0d exp %0d", k, fall_cyc[k] - base, 4 + 16 * k); end
                n_cmp++; if (fall_data[k] !== bytes[k] || fall_prev[k] !== bytes[k]) begin
                    n_bad++; $display("FAIL burst_setup_data k=%0d got %h/%h exp %h", k, fall_prev[k], fall_data[k], bytes[k]);
                end
            end
            if (k < rise_cyc.size()) begin
                n_cmp++; if (rise_cyc[k] - base != 8 + 16 * k || rise_data[k] !== bytes[k]) begin
                    n_bad++; $display("FAIL burst_hold k=%0d got cyc %0d data %h exp cyc %0d data %h", k, rise_cyc[k] - base, rise_data[k], 8 + 16 * k, bytes[k]);
                end
            end
            if (k < done_cyc.size()) begin
                n_cmp++; if (done_cyc[k] - base != 10 + 16 * k) begin n_bad++; $display("FAIL burst_done k=%0d got %0d exp %0d", k, done_cyc[k] - base, 10 + 16 * k); end
            end
            $display("burst: byte %h", bytes[k]);
        end
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL burst_busy_end got %b exp 0", bus_a.busy); end
    endtask

    task automatic test_full();
        logic [7:0] bytes [6] = '{8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
        int   base;
        int   idx = 0;
        int   last_accept = -1;
        logic present;
        logic accepted;
        clear_mon();
        base = cyc;
        for (int c = 0; c < 106; c++) begin
            present = (c == 0) || (c >= 2 && idx < 6);
            bus_a.in_valid = present;
            if (present) bus_a.in_data = bytes[idx];
            if (c >= 2 && c <= 5) begin
                n_cmp++; if (bus_a.in_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_open c=%0d got %b exp 1", c, bus_a.in_ready); end
            end
            if ((c >= 6 && c <= 17) || c == 19) begin
                n_cmp++; if (bus_a.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_closed c=%0d got %b exp 0", c, bus_a.in_ready); end
            end
            if (c == 18) begin
                n_cmp++; if (bus_a.in_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_reopen got %b exp 1", bus_a.in_ready); end
                n_cmp++; if (bus_a.fifo_level !== 3'd3) begin n_bad++; $display("FAIL full_level18 got %0d exp 3", bus_a.fifo_level); end
            end
            if (c == 6 || c == 19) begin
                n_cmp++; if (bus_a.fifo_level !== 3'd4) begin n_bad++; $display("FAIL full_level c=%0d got %0d exp 4", c, bus_a.fifo_level); end
            end
            accepted = present && bus_a.in_ready;
            tick();
            if (accepted) begin
                idx++;
                last_accept = c;
            end
        end
        bus_a.in_valid = 1'b0;
        n_cmp++; if (last_accept != 18) begin n_bad++; $display("FAIL full_fifth_accept got %0d exp 18", last_accept); end
        n_cmp++; if (fall_cyc.size() != 6) begin n_bad++; $display("FAIL full_pulses got %0d exp 6", fall_cyc.size()); end
        n_cmp++; if (done_cyc.size() != 6) begin n_bad++; $display("FAIL full_dones got %0d exp 6", done_cyc.size()); end
        for (int k = 0; k < 6 && k < fall_cyc.size(); k++) begin
            n_cmp++; if (fall_cyc[k] - base != 4 + 16 * k || fall_data[k] !== bytes[k]) begin
                n_bad++; $display("FAIL full_write k=%0d got cyc %0d data %h exp cyc %0d data %h", k, fall_cyc[k] - base, fall_data[k], 4 + 16 * k, bytes[k]);
            end
            $display("full: byte %h", bytes[k]);
        end
        n_cmp++; if (bus_a.fifo_level !== 3'd0 || bus_a.busy !== 1'b0) begin
            n_bad++; $display("FAIL full_end got level %0d busy %b exp 0/0", bus_a.fifo_level, bus_a.busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] bytes [4] = '{8'h81, 8'h82, 8'h83, 8'h84};
        for (int c = 0; c < 5; c++) begin
            bus_a.in_valid = (c < 4);
            if (c < 4) bus_a.in_data = bytes[c];
            tick();
        end
        bus_a.in_valid = 1'b0;
        // cycle 5: first byte in STROBE, three bytes queued
        n_cmp++; if (bus_a.web !== 1'b0) begin n_bad++; $display("FAIL mid_pre_web got %b exp 0", bus_a.web); end
        n_cmp++; if (bus_a.fifo_level !== 3'd3) begin n_bad++; $display("FAIL mid_pre_level got %0d exp 3", bus_a.fifo_level); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus_a.web !== 1'b1) begin n_bad++; $display("FAIL mid_async_web got %b exp 1", bus_a.web); end
        n_cmp++; if (bus_a.fifo_level !== 3'd0) begin n_bad++; $display("FAIL mid_level got %0d exp 0", bus_a.fifo_level); end
        n_cmp++; if (bus_a.in_ready !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.data !== 8'h00) begin
            n_bad++; $display("FAIL mid_outputs got ready %b busy %b data %h exp 1/0/00", bus_a.in_ready, bus_a.busy, bus_a.data);
        end
        @(negedge clk);
        clear_mon();
        rst_n = 1'b1;
        repeat (40) tick();
        n_cmp++; if (fall_cyc.size() != 0 || done_cyc.size() != 0) begin
            n_bad++; $display("FAIL mid_after_release got %0d pulses %0d dones exp 0/0", fall_cyc.size(), done_cyc.size());
        end
        n_cmp++; if (bus_a.busy !== 1'b0 || bus_a.web !== 1'b1) begin
            n_bad++; $display("FAIL mid_idle got busy %b web %b exp 0/1", bus_a.busy, bus_a.web);
        end
        $display("reset_mid: queued bytes discarded");
    endtask

    task automatic test_timing_params();
        logic [7:0] bytes [3] = '{8'h11, 8'h22, 8'h33};
        logic [7:0] exp_data;
        logic       exp_web;
        logic       exp_done;
        for (int c = 0; c < 16; c++) begin
            bus_b.in_valid = (c < 3);
            if (c < 3) bus_b.in_data = bytes[c];
            exp_web  = !(c == 3 || c == 7 || c == 11);
            exp_done = (c == 5 || c == 9 || c == 13);
            exp_data = (c < 2) ? 8'h00 : (c < 6) ? 8'h11 : (c < 10) ? 8'h22 : 8'h33;
            n_cmp++; if (bus_b.web !== exp_web) begin n_bad++; $display("FAIL tp_web c=%0d got %b exp %b", c, bus_b.web, exp_web); end
            n_cmp++; if (bus_b.data !== exp_data) begin n_bad++; $display("FAIL tp_data c=%0d got %h exp %h", c, bus_b.data, exp_data); end
            n_cmp++; if (bus_b.done !== exp_done) begin n_bad++; $display("FAIL tp_done c=%0d got %b exp %b", c, bus_b.done, exp_done); end
            n_cmp++; if (bus_b.busy !== (c >= 1 && c <= 13)) begin n_bad++; $display("FAIL tp_busy c=%0d got %b exp %b", c, bus_b.busy, (c >= 1 && c <= 13)); end
            tick();
        end
        bus_b.in_valid = 1'b0;
        $display("timing_params: bytes 11 22 33 at 4-cycle period");
    endtask

    initial begin
        bus_a.in_valid = 1'b0; bus_a.in_data = 8'h00;
        bus_b.in_valid = 1'b0; bus_b.in_data = 8'h00;
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_reset_mid();
        test_timing_params();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d, expected completion earlier", cyc);
        $fatal(1, "watchdog");
    end
endmodule
